serial_queue_top: RTL and testbench

Serial-in byte queue with serial-out. Single data bits arrive on data_in, each qualified by a rising edge of write_in. They are assembled MSB-first into bytes and pushed into an on-chip FIFO. Each dequeue request pops one byte and shifts it out MSB-first on data_out. The block is the top-level of the serial link board design, running from a 1 MHz clock.

---
 rtl/serial_queue_pkg.sv | 14 +
 rtl/serial_queue_byte_fifo.sv | 74 +++++++
 rtl/serial_queue_top.sv | 169 ++++++++++++++++
 tb/tb_serial_queue_top.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_queue_pkg.sv
// Shared types and default sizing for the serial byte queue.
// INPUT_SYNC_EN (see serial_queue_top) does not change anything in this package.
package serial_queue_pkg;

    localparam int SQ_WIDTH = 8;
    localparam int SQ_DEPTH = 8;
    localparam int PTR_W    = $clog2(SQ_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/serial_queue_byte_fifo.sv
// byte_fifo: circular-buffer FIFO with occupancy count.
// A push while full is dropped unless a pop happens in the same cycle.
module byte_fifo
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH,
    parameter int DEPTH = SQ_DEPTH,
    parameter int PW    = PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Popping frees a slot, so a full FIFO still accepts a same-cycle push.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/serial_queue_top.sv
// serial_queue_top: serial-in MSB-first byte assembly, FIFO, serial-out transmitter.
// Define INPUT_SYNC_EN to put a 2-flop synchronizer on write_in, data_in and dequeue_in.
module serial_queue_top
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH,
    parameter int DEPTH = SQ_DEPTH
) (
    input  logic clock1M,
    input  logic reset,
    input  logic data_in,
    input  logic write_in,
    input  logic dequeue_in,
    output logic data_out,
    output logic status_out
);

    localparam int BC_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Input bundle order: {write, data, dequeue}.
    logic [2:0] in_s;

`ifdef INPUT_SYNC_EN
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {write_in, data_in, dequeue_in};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = {write_in, data_in, dequeue_in};
`endif

    logic [1:0] prev_q, prev_d;
    logic       wr_edge;
    logic       deq_edge;
    logic       data_bit;

    assign prev_d   = {in_s[2], in_s[0]};
    assign wr_edge  = in_s[2] & ~prev_q[1];
    assign deq_edge = in_s[0] & ~prev_q[0];
    assign data_bit = in_s[1];

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic             push_q, push_d;
    logic [WIDTH-1:0] push_word_q, push_word_d;

    // The completed word is held one cycle in push_word_q before entering the FIFO.
    always_comb begin
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (wr_edge) begin
            shreg_d = {shreg_q[WIDTH-2:0], data_bit};
            if (bitcnt_q == BC_W'(WIDTH - 1)) begin
                bitcnt_d    = '0;
                push_d      = 1'b1;
                push_word_d = {shreg_q[WIDTH-2:0], data_bit};
            end else begin
                bitcnt_d = bitcnt_q + BC_W'(1);
            end
        end
    end

    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             pop;

    tx_state_t        state_q;
    logic [WIDTH-1:0] txreg_q;
    logic [BC_W-1:0]  txcnt_q;
    logic             data_out_q;
    logic             status_q, status_d;

    assign pop       = deq_edge & (state_q == IDLE) & ~fifo_empty;
    assign fifo_push = push_q & (~fifo_full | pop);
    assign status_d  = (fifo_count != '0);

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    ($clog2(DEPTH))
    ) u_fifo (
        .clk       (clock1M),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (push_word_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            status_q    <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            status_q    <= status_d;
        end
    end

    // Dequeue edges outside IDLE are dropped, never remembered.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            txreg_q    <= '0;
            txcnt_q    <= '0;
            data_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_out_q <= 1'b0;
                    if (pop) begin
                        txreg_q <= fifo_head;
                        txcnt_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_out_q <= txreg_q[WIDTH-1];
                    txreg_q    <= {txreg_q[WIDTH-2:0], 1'b0};
                    if (txcnt_q == BC_W'(WIDTH - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        txcnt_q <= txcnt_q + BC_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    data_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_serial_queue_top.sv
// Self-checking bench for serial_queue_top: queue-based reference model plus literal checks.
// Follows INPUT_SYNC_EN so the model latency tracks the build.
module tb_serial_queue_top;
    import serial_queue_pkg::*;

    localparam int W = SQ_WIDTH;
    localparam int D = SQ_DEPTH;
`ifdef INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic data_in    = 1'b0;
    logic write_in   = 1'b0;
    logic dequeue_in = 1'b0;
    logic data_out;
    logic status_out;

    int errors      = 0;
    int checks      = 0;
    int fail_prints = 0;

    serial_queue_top #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clock1M    (clk),
        .reset      (rst_n),
        .data_in    (data_in),
        .write_in   (write_in),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .status_out (status_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
            end
        end
    endtask

    // Reference model: bytes held in a queue; a transmission is a byte plus its start cycle.
    logic [W-1:0] exp_q[$];
    logic         w_dl[$];
    logic         d_dl[$];
    logic         q_dl[$];
    logic [W-1:0] acc;
    int           acc_n;
    logic         pend_v;
    logic [W-1:0] pend_w;
    int           tx_start;
    logic [W-1:0] tx_byte;
    int           prev_size;
    logic         wp;
    logic         qp;
    int           cyc = 0;
    logic         exp_do;
    logic         exp_st;

    task automatic model_reset();
        exp_q.delete();
        w_dl.delete();
        d_dl.delete();
        q_dl.delete();
        acc       = '0;
        acc_n     = 0;
        pend_v    = 1'b0;
        pend_w    = '0;
        tx_start  = -1000;
        tx_byte   = '0;
        prev_size = 0;
        wp        = 1'b0;
        qp        = 1'b0;
        exp_do    = 1'b0;
        exp_st    = 1'b0;
    endtask

    always @(posedge clk) begin
        logic ws, ds, qs, rs, w, d, q;
        ws = write_in;
        ds = data_in;
        qs = dequeue_in;
        rs = rst_n;
        #1;
        if (!rs) begin
            model_reset();
        end else begin
            w_dl.push_back(ws);
            d_dl.push_back(ds);
            q_dl.push_back(qs);
            if (w_dl.size() > LAT) begin
                w = w_dl.pop_front();
                d = d_dl.pop_front();
                q = q_dl.pop_front();
            end else begin
                w = 1'b0;
                d = 1'b0;
                q = 1'b0;
            end
            exp_st = (prev_size != 0);
            if (q && !qp && cyc >= tx_start + W + 1 && exp_q.size() > 0) begin
                tx_byte  = exp_q.pop_front();
                tx_start = cyc;
            end
            if (pend_v) begin
                if (exp_q.size() < D) exp_q.push_back(pend_w);
                pend_v = 1'b0;
            end
            if (w && !wp) begin
                acc = {acc[W-2:0], d};
                acc_n++;
                if (acc_n == W) begin
                    pend_v = 1'b1;
                    pend_w = acc;
                    acc_n  = 0;
                end
            end
            wp = w;
            qp = q;
            prev_size = exp_q.size();
            if (cyc >= tx_start + 1 && cyc <= tx_start + W)
                exp_do = tx_byte[W - 1 - (cyc - tx_start - 1)];
            else
                exp_do = 1'b0;
        end
        cyc++;
        check("data_out", 32'(data_out), 32'(exp_do));
        check("status_out", 32'(status_out), 32'(exp_st));
    end

    task automatic send_bits(input logic [W-1:0] v, input int n, input int hi, input int lo);
        @(negedge clk);
        for (int i = W - 1; i >= W - n; i--) begin
            data_in  = v[i];
            write_in = 1'b1;
            repeat (hi) @(negedge clk);
            write_in = 1'b0;
            data_in  = 1'($urandom_range(0, 1));
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic do_deq(output logic [W-1:0] got, input bit repulse);
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        repeat (LAT) @(negedge clk);
        got = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            got = {got[W-2:0], data_out};
            if (repulse && i == 1) dequeue_in = 1'b1;
            if (repulse && i == 2) dequeue_in = 1'b0;
        end
    endtask

    task automatic pulse_deq();
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_status", 32'(status_out), 32'd0);
        rst_n = 1'b1;

        do_deq(got, 1'b0);
        check("empty_deq", 32'(got), 32'h00);
        check("empty_status", 32'(status_out), 32'd0);

        send_bits(8'hA5, W, 10, 10);
        check("status_after_a5", 32'(status_out), 32'd1);
        send_bits(8'h3C, W, 10, 10);
        do_deq(got, 1'b0);
        check("deq_a5", 32'(got), 32'hA5);
        repeat (100) @(negedge clk);
        do_deq(got, 1'b0);
        check("deq_3c", 32'(got), 32'h3C);
        repeat (5) @(negedge clk);
        check("status_drained", 32'(status_out), 32'd0);

        for (int b = 1; b <= 9; b++) send_bits(W'(b), W, 2, 2);
        repeat (5) @(negedge clk);
        check("status_full", 32'(status_out), 32'd1);
        for (int b = 1; b <= 8; b++) begin
            do_deq(got, 1'b0);
            check($sformatf("overflow_deq_%0d", b), 32'(got), 32'(b));
        end
        do_deq(got, 1'b0);
        check("overflow_ninth", 32'(got), 32'h00);
        repeat (3) @(negedge clk);
        check("overflow_status", 32'(status_out), 32'd0);

        send_bits(8'hFF, 4, 3, 3);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bits(8'hA5, W, 3, 3);
        do_deq(got, 1'b0);
        check("after_reset_a5", 32'(got), 32'hA5);

        send_bits(8'hF0, W, 2, 3);
        send_bits(8'h0F, W, 3, 2);
        do_deq(got, 1'b1);
        check("shift_ignore_f0", 32'(got), 32'hF0);
        repeat (20) @(negedge clk);
        check("status_0f_left", 32'(status_out), 32'd1);
        do_deq(got, 1'b0);
        check("later_0f", 32'(got), 32'h0F);

        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 1) == 1) begin
                rb = W'($urandom_range(0, (1 << W) - 1));
                send_bits(rb, W, $urandom_range(1, 4), $urandom_range(1, 4));
            end else begin
                pulse_deq();
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end
        for (int k = 0; k < D + 1; k++) begin
            pulse_deq();
            repeat (W + 2) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
